// File: rtl/instr_fetch_buf_pkg.sv
// Shared types for the double-buffered instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_buf_if.sv
// Loader/decode/control bundle for instr_fetch_buf; slave is the fetch block, master drives it.
interface instr_fetch_buf_if #(
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16
);
    localparam int PC_W = $clog2(DEPTH);

    logic               load_valid;
    logic [INSTR_W-1:0] load_data [DEPTH];
    logic               load_ready;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               br_valid;
    logic [PC_W-1:0]    br_target;
    logic               halt;
    logic               halted;
    logic               shadow_full;

    modport master (
        output load_valid, load_data, out_ready, br_valid, br_target, halt,
        input  load_ready, out_valid, out_instr, out_pc, halted, shadow_full
    );

    modport slave (
        input  load_valid, load_data, out_ready, br_valid, br_target, halt,
        output load_ready, out_valid, out_instr, out_pc, halted, shadow_full
    );

endinterface

// File: rtl/instr_fetch_buf_bank.sv
// One instruction bank: whole-bank write, asynchronous indexed read.
module instr_bank #(
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16,
    localparam int PC_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [INSTR_W-1:0] wdata [DEPTH],
    input  logic [PC_W-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_buf.sv
// Double-buffered fetch: sequences PC through the active bank while the shadow bank refills.
module instr_fetch_buf
    import fetch_pkg::*;
#(
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16,
    parameter bit LOOP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_buf_if.slave  bus
);

    localparam int PC_W = $clog2(DEPTH);

    fetch_state_e       state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               act_q, act_d;
    logic               shadow_q, shadow_d;

    logic               load_ready;
    logic               load_fire;
    logic               out_valid;
    logic               accept;
    logic               last;
    logic [INSTR_W-1:0] rd0, rd1;

    assign load_ready = (state_q != RUN) || !shadow_q;
    assign load_fire  = bus.load_valid && load_ready;
    assign out_valid  = (state_q == RUN) && !bus.br_valid && !bus.halt;
    assign accept     = out_valid && bus.out_ready;
    assign last       = accept && (pc_q == PC_W'(DEPTH - 1));

    // Incoming banks always land in the inactive slot; act flips on swap.
    instr_bank #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (load_fire && act_q),
        .wdata (bus.load_data),
        .raddr (pc_q),
        .rdata (rd0)
    );

    instr_bank #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (load_fire && !act_q),
        .wdata (bus.load_data),
        .raddr (pc_q),
        .rdata (rd1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            pc_q     <= '0;
            act_q    <= 1'b0;
            shadow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            act_q    <= act_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        act_d    = act_q;
        shadow_d = shadow_q;
        unique case (state_q)
            EMPTY, HALTED: begin
                if (bus.halt) begin
                    state_d = HALTED;
                end else if (load_fire) begin
                    state_d  = RUN;
                    act_d    = !act_q;
                    pc_d     = '0;
                    shadow_d = 1'b0;
                end
            end
            RUN: begin
                if (bus.halt) begin
                    // Any pending or simultaneously arriving bank is dropped.
                    state_d  = HALTED;
                    shadow_d = 1'b0;
                end else if (bus.br_valid) begin
                    pc_d = bus.br_target;
                    if (load_fire) shadow_d = 1'b1;
                end else if (last) begin
                    if (shadow_q || load_fire) begin
                        act_d    = !act_q;
                        pc_d     = '0;
                        shadow_d = 1'b0;
                    end else if (LOOP_EN) begin
                        pc_d = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end else begin
                    if (accept)    pc_d     = pc_q + PC_W'(1);
                    if (load_fire) shadow_d = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign bus.load_ready  = load_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_instr   = out_valid ? (act_q ? rd1 : rd0) : '0;
    assign bus.out_pc      = pc_q;
    assign bus.halted      = (state_q == HALTED);
    assign bus.shadow_full = shadow_q;

endmodule

// File: doc/instr_fetch_buf.md
# instr_fetch_buf

Parametrised, double-buffered instruction fetch stage. Holds two banks of `DEPTH` instructions loaded as whole blocks from the instruction loader, sequences a program counter through the active bank, and presents one instruction per cycle to decode over a valid/ready handshake. It supports branch redirect, halt, and a background refill of the shadow bank while the active bank executes. It sits between the block loader and the control decode stage.

## Interface
- `INSTR_W`, 32, instruction width in bits
- `DEPTH`, 16, instructions per bank; power of two, ≥ 2
- `PC_W`, `$clog2(DEPTH)`, PC width (derived, do not override)
- `LOOP_EN`, 1, 1: wrap within the active bank when no shadow bank is ready; 0: go EMPTY at end of bank

- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `load_valid`  in  1  loader offers a full bank
- `load_data`  in  `INSTR_W` x `DEPTH` (unpacked)  bank contents; index 0 is executed first
- `load_ready`  out  1  block can accept a bank this cycle
- `out_valid`  out  1  `out_instr` and `out_pc` valid
- `out_ready`  in  1  decode accepts the instruction
- `out_instr`  out  `INSTR_W`  instruction at PC; 0 when `out_valid`=0
- `out_pc`  out  `PC_W`  PC of `out_instr`
- `br_valid`  in  1  redirect request
- `br_target`  in  `PC_W`  redirect PC within the active bank
- `halt`  in  1  stop fetch
- `halted`  out  1  in state HALTED
- `shadow_full`  out  1  shadow bank loaded and pending

## Operation
- State is held in `act` (active bank index), `pc`, `shadow_full`, and a 3-state FSM: EMPTY, RUN, HALTED.
- `load_fire` = `load_valid & load_ready`. Data is always written to bank `~act`.
- `load_ready` = (state != RUN) | !`shadow_full`.
- `accept` = `out_valid & out_ready`. `last` = `accept & (pc == DEPTH-1)`.
- EMPTY / HALTED:
  - `out_valid`=0.
  - On `load_fire`: flip `act`, `pc`←0, go to RUN, `shadow_full` stays 0.
  - `halt` in EMPTY goes to HALTED.
- RUN: `out_valid`=1 unless `br_valid` or `halt` is high that cycle. Priority, highest first:
  1. `halt`: go to HALTED, `shadow_full`←0 (pending bank discarded), PC held. A simultaneous `load_fire` is written and discarded.
  2. `br_valid`: `pc`←`br_target`, no accept, no swap. A simultaneous `load_fire` still sets `shadow_full`.
  3. `last`: if `shadow_full | load_fire`, flip `act`, `pc`←0, `shadow_full`←0.
     - Otherwise, if `LOOP_EN`: `pc`←0 on the same bank.
     - Otherwise: go to EMPTY.
  4. `accept`: `pc`←`pc`+1.
  - Separately, `load_fire` without a swap sets `shadow_full`←1.
- PC arithmetic is modulo `DEPTH`; there is no overflow flag.

## Timing
- Reset values:
  - State EMPTY; `pc`=0, `act`=0, `shadow_full`=0.
  - Both banks cleared to 0.
  - Outputs: `out_valid`=0, `out_instr`=0, `out_pc`=0, `load_ready`=1, `halted`=0.
- Reset mid-operation discards everything immediately, asynchronously.
- Read path is combinational from registered `pc`/`act`; `out_instr` is valid in the same cycle as `out_valid`.
- `load_fire` at edge t makes the first instruction visible at t+1 (EMPTY/HALTED path).
- Throughput is 1 instruction/cycle, including across a bank swap: no bubble when the shadow bank is ready at `last`.
- `br_valid` at cycle t: the target instruction is presented at t+1.
- `out_valid` may drop without `out_ready` only on `br_valid`, `halt`, or entry to EMPTY.
- Inputs are sampled on the rising edge only.

## Structure
- Package `fetch_pkg`: `fetch_state_e` {EMPTY, RUN, HALTED}.
- Sub-module `instr_bank`: `DEPTH` x `INSTR_W` register file with whole-bank write enable and async indexed read. Instantiated twice.
- Top level holds the FSM, PC, `act`, and `shadow_full`.

## Test plan
- Reset, then load bank A = {0x100+i}, hold `out_ready`=1: `out_instr` is 0x100..0x10F on cycles 1..16, then 0x100 again (`LOOP_EN`=1).
- Load bank B = {0x200+i} while running A at pc 5: `shadow_full`=1 at the next cycle; after 0x10F the next cycle shows 0x200 with no bubble; `shadow_full`=0.
- `br_valid` with target 3 while at pc 9: `out_valid`=0 that cycle, next cycle `out_pc`=3 and `out_instr`=0x103.
- `halt` and `br_valid` together while `shadow_full`=1: `halted`=1, `shadow_full`=0, `load_ready`=1. A new load resumes at pc 0 of the new bank one cycle later.
- `LOOP_EN`=0, no shadow, accept pc 15: state is EMPTY and `out_valid`=0 next cycle. Load arriving in the same cycle as `last` swaps with no bubble instead.
- `out_ready`=0 for 4 cycles at pc 7: `out_pc` is held at 7 and `out_instr` is stable. Assert `rst_n`=0 mid-run: all outputs take their reset values immediately.
